// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared encodings for the store read-modify-write sequencer
package store_pkg;

    localparam logic [1:0] SEL_BYTE = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Byte and halfword stores need the old word; 10 and 11 both mean a full word.
    function automatic logic is_partial(input logic [1:0] sel);
        return (sel == SEL_BYTE) || (sel == SEL_HALF);
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - merges the low lane of the store data into the old memory word
module store_lane_merge
    import store_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic [31:0] b,
    input  logic [31:0] mdr,
    output logic [31:0] merged
);

    always_comb begin
        merged = b;
        case (sel)
            SEL_BYTE: merged = {mdr[31:8], b[7:0]};
            SEL_HALF: merged = {mdr[31:16], b[15:0]};
            default:  merged = b;
        endcase
    end

endmodule

// File: rtl/store_rmw_seq.sv
// rtl/store_rmw_seq.sv - sequences sb/sh as read-modify-write and sw as a single write
module store_rmw_seq
    import store_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  storeSel,
    input  logic [31:0] addrIn,
    input  logic [31:0] bOut,
    input  logic [31:0] memRdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] memAddr,
    output logic        memRd,
    output logic        memWr,
    output logic [31:0] memWdata,
    output logic [31:0] mdrOut
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      mdr_q, mdr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      merged;

    store_lane_merge u_merge (
        .sel    (sel_q),
        .b      (b_q),
        .mdr    (memRdata),
        .merged (merged)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            b_q     <= '0;
            mdr_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            b_q     <= b_d;
            mdr_q   <= mdr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        b_d     = b_q;
        mdr_d   = mdr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        busy    = (state_q != ST_IDLE);
        done    = 1'b0;
        memRd   = 1'b0;
        memWr   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d  = storeSel;
                    addr_d = addrIn;
                    b_d    = bOut;
                    if (is_partial(storeSel)) begin
                        state_d = ST_RD;
                    end else begin
                        // Full word skips the read; the old word in mdr is left alone.
                        wdata_d = bOut;
                        state_d = ST_WR;
                    end
                end
            end
            ST_RD: begin
                memRd   = 1'b1;
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    mdr_d   = memRdata;
                    wdata_d = merged;
                    state_d = ST_WR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR: begin
                memWr   = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign memAddr  = addr_q;
    assign memWdata = wdata_q;
    assign mdrOut   = mdr_q;

endmodule
